// File: rtl/grid_supervisor.sv
// grid_supervisor: run controller for a bank of parallel grid solvers.
//   One start request launches every solver together and counts RUN cycles.
//   The run ends on the first success, on exhaustion (every solver done and none
//   succeeded), on an abort, or when the cycle budget runs out. The result is then
//   published with a one-cycle done pulse and held until the next start.
// Ports:
//   clock, reset          single clock; asynchronous active-high reset
//   start                 run request, sampled only in IDLE
//   abort                 cancel the current run, sampled only in RUN
//   solver_start[N]       one-cycle launch pulse to every solver
//   solver_done[N]        per-solver done (pulse or level)
//   solver_success[N]     per-solver result, qualified by the matching done bit
//   busy                  high in LAUNCH, RUN and REPORT
//   done                  one-cycle pulse when a result is published
//   success/timed_out/aborted  held result flags (at most one set)
//   winner                held lowest-index successful solver
//   cycle_count           held RUN cycles elapsed, including the deciding cycle

// Per-solver bookkeeping: remembers whether this solver has reported done during
// the current run and exposes this cycle's success and "finished" terms.
module grid_supervisor_lane (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic run,
  input  logic sdone,
  input  logic ssucc,
  output logic succ_now,
  output logic fin
);
  logic seen;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)    seen <= 1'b0;
    else if (clr) seen <= 1'b0;
    else if (run) seen <= seen | sdone;
  end

  // A level-held done counts this cycle as well as any earlier pulse.
  assign fin      = seen | sdone;
  assign succ_now = sdone & ssucc;
endmodule

module grid_supervisor #(
  parameter int NUM_SOLVERS = 4,
  parameter int MAX_CYCLES  = 10000,
  parameter int CYCLE_W     = $clog2(MAX_CYCLES + 1),
  parameter int IDX_W       = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  output logic [NUM_SOLVERS-1:0] solver_start,
  input  logic [NUM_SOLVERS-1:0] solver_done,
  input  logic [NUM_SOLVERS-1:0] solver_success,
  output logic                   busy,
  output logic                   done,
  output logic                   success,
  output logic                   timed_out,
  output logic                   aborted,
  output logic [IDX_W-1:0]       winner,
  output logic [CYCLE_W-1:0]     cycle_count
);
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, REPORT} state_t;
  state_t state;

  logic [NUM_SOLVERS-1:0] succ_now, fin;
  logic                   clr, run;
  logic [IDX_W-1:0]       win_idx;
  logic [CYCLE_W-1:0]     cnt_nxt;
  logic                   last, decide;

  assign clr = (state == IDLE) && start;
  assign run = (state == RUN);

  for (genvar g = 0; g < NUM_SOLVERS; g++) begin : g_lane
    grid_supervisor_lane u_lane (
      .clock    (clock),
      .reset    (reset),
      .clr      (clr),
      .run      (run),
      .sdone    (solver_done[g]),
      .ssucc    (solver_success[g]),
      .succ_now (succ_now[g]),
      .fin      (fin[g])
    );
  end

  // Lowest set index wins: scan downward so the last hit is the lowest.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_SOLVERS - 1; i >= 0; i--)
      if (succ_now[i]) win_idx = IDX_W'(i);
  end

  // cycle_count holds the cycles already completed, so this RUN cycle is
  // number cycle_count+1; it is the last allowed one when that equals MAX_CYCLES.
  assign cnt_nxt = cycle_count + CYCLE_W'(1);
  assign last    = (cycle_count == CYCLE_W'(MAX_CYCLES - 1));
  assign decide  = (|succ_now) | abort | (&fin) | last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      solver_start <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      success      <= 1'b0;
      timed_out    <= 1'b0;
      aborted      <= 1'b0;
      winner       <= '0;
      cycle_count  <= '0;
    end else begin
      solver_start <= '0;
      done         <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state        <= LAUNCH;
          solver_start <= '1;
          busy         <= 1'b1;
          success      <= 1'b0;
          timed_out    <= 1'b0;
          aborted      <= 1'b0;
          winner       <= '0;
          cycle_count  <= '0;
        end
        LAUNCH: state <= RUN;
        RUN: begin
          cycle_count <= cnt_nxt;
          // Priority: success, abort, exhaustion (no flag), timeout.
          if (|succ_now) begin
            success <= 1'b1;
            winner  <= win_idx;
          end else if (abort) begin
            aborted <= 1'b1;
          end else if (!(&fin) && last) begin
            timed_out <= 1'b1;
          end
          if (decide) begin
            state <= REPORT;
            done  <= 1'b1;
          end
        end
        REPORT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_grid_supervisor.sv
// Self-checking bench for grid_supervisor (4 solvers, budget of 16 RUN cycles).
// Each run is described by per-RUN-cycle stimulus tables; a reference model walks
// those tables with the published decision rules to predict the outcome.
module tb_grid_supervisor;
  localparam int N    = 4;
  localparam int MAXC = 16;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  solver_start;
  logic [N-1:0]  solver_done = '0;
  logic [N-1:0]  solver_success = '0;
  logic          busy, done, success, timed_out, aborted;
  logic [IW-1:0] winner;
  logic [CW-1:0] cycle_count;

  grid_supervisor #(.NUM_SOLVERS(N), .MAX_CYCLES(MAXC)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .solver_start(solver_start), .solver_done(solver_done),
    .solver_success(solver_success), .busy(busy), .done(done),
    .success(success), .timed_out(timed_out), .aborted(aborted),
    .winner(winner), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus for RUN cycles 1..MAXC+2 (index = RUN cycle number).
  logic [N-1:0] dv [0:MAXC+2];
  logic [N-1:0] sv [0:MAXC+2];
  int ab_at, st_at;

  // Expected outcome.
  int e_cyc, e_succ, e_to, e_ab, e_win;

  task automatic clr_stim();
    for (int k = 0; k <= MAXC + 2; k++) begin dv[k] = '0; sv[k] = '0; end
    ab_at = 0; st_at = 0;
  endtask

  // Reference: walk the cycles, first rule that fires decides the run.
  task automatic model_run();
    logic [N-1:0] seen;
    seen = '0;
    e_cyc = 0; e_succ = 0; e_to = 0; e_ab = 0; e_win = 0;
    for (int k = 1; k <= MAXC; k++) begin
      logic [N-1:0] sn;
      sn = dv[k] & sv[k];
      if (sn != 0) begin
        e_succ = 1;
        for (int i = N - 1; i >= 0; i--) if (sn[i]) e_win = i;
      end else if (ab_at == k) begin
        e_ab = 1;
      end else if ((seen | dv[k]) == {N{1'b1}}) begin
        // exhausted: no flag
      end else if (k == MAXC) begin
        e_to = 1;
      end else begin
        seen = seen | dv[k];
        continue;
      end
      e_cyc = k;
      break;
    end
  endtask

  task automatic do_run(input string name);
    int got;
    model_run();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    // LAUNCH cycle: pulse out, old results already cleared on the start edge.
    chk({name, ".launch"}, solver_start, 4'hf);
    chk({name, ".busy"}, busy, 1);
    chk({name, ".clr_succ"}, success, 0);
    chk({name, ".clr_cnt"}, cycle_count, 0);
    got = 0;
    for (int k = 1; k <= MAXC + 2; k++) begin
      @(negedge clock);
      if (k == 1) chk({name, ".pulse_1cyc"}, solver_start, 0);
      if (done) begin
        got = k - 1;
        // Keep feeding the next table entry during REPORT; it must be ignored.
        solver_done = dv[k]; solver_success = sv[k]; abort = (k == ab_at); start = 1'b0;
        break;
      end
      solver_done = dv[k]; solver_success = sv[k];
      abort = (k == ab_at); start = (k == st_at);
    end
    if (got == 0) chk({name, ".no_done"}, 0, 1);
    chk({name, ".dec_cycle"}, got, e_cyc);
    chk({name, ".success"}, success, e_succ);
    chk({name, ".timed_out"}, timed_out, e_to);
    chk({name, ".aborted"}, aborted, e_ab);
    chk({name, ".winner"}, winner, e_win);
    chk({name, ".cycle_count"}, cycle_count, e_cyc);
    chk({name, ".busy_rep"}, busy, 1);
    @(negedge clock);
    solver_done = '0; solver_success = '0; abort = 1'b0; start = 1'b0;
    chk({name, ".done_1cyc"}, done, 0);
    chk({name, ".busy_drop"}, busy, 0);
    @(negedge clock);
    chk({name, ".held_succ"}, success, e_succ);
    chk({name, ".held_win"}, winner, e_win);
    chk({name, ".held_cnt"}, cycle_count, e_cyc);
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".start"}, solver_start, 0);
    chk({name, ".busy"}, busy, 0);
    chk({name, ".done"}, done, 0);
    chk({name, ".succ"}, success, 0);
    chk({name, ".to"}, timed_out, 0);
    chk({name, ".ab"}, aborted, 0);
    chk({name, ".win"}, winner, 0);
    chk({name, ".cnt"}, cycle_count, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset then idle
    clr_stim();
    repeat (2) @(negedge clock);
    chk_zero("rst");
    reset = 1'b0;
    @(negedge clock);
    chk_zero("idle");

    // 2: solver 2 succeeds on RUN cycle 5
    clr_stim(); dv[5] = 4'b0100; sv[5] = 4'b0100;
    do_run("succ2");

    // async reset while results are held in IDLE
    #2 reset = 1'b1;
    #1 chk_zero("rst_idle");
    @(negedge clock); reset = 1'b0;

    // 3: solvers 1 and 3 together, solver 0 one cycle later
    clr_stim(); dv[4] = 4'b1010; sv[4] = 4'b1010; dv[5] = 4'b0001; sv[5] = 4'b0001;
    do_run("tie");

    // 4: staggered exhaustion
    clr_stim(); dv[3] = 4'b0001; dv[4] = 4'b0010; dv[7] = 4'b0100; dv[9] = 4'b1000;
    do_run("exhaust");

    // 5: timeout, then success on the final cycle
    clr_stim();
    do_run("timeout");
    clr_stim(); dv[16] = 4'b0001; sv[16] = 4'b0001;
    do_run("succ_last");

    // 6: abort on cycle 3 with a start while busy
    clr_stim(); ab_at = 3; st_at = 2;
    do_run("abort");

    // success beats abort in the same cycle; done without success bit is not success
    clr_stim(); dv[2] = 4'b0011; sv[2] = 4'b0010; ab_at = 2;
    do_run("succ_vs_abort");

    // reset during LAUNCH drops solver_start immediately
    clr_stim();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    chk("launch_pre", solver_start, 4'hf);
    #2 reset = 1'b1;
    #1 chk_zero("rst_launch");
    @(negedge clock); reset = 1'b0;

    // reset mid-RUN
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (4) @(negedge clock);
    chk("mid_busy", busy, 1);
    chk("mid_cnt_nz", int'(cycle_count != 0), 1);
    #2 reset = 1'b1;
    #1 chk_zero("rst_run");
    @(negedge clock); reset = 1'b0;

    // recovery after reset
    clr_stim(); dv[1] = 4'b1000; sv[1] = 4'b1000;
    do_run("recover");

    // randomized runs
    for (int r = 0; r < 40; r++) begin
      clr_stim();
      for (int k = 1; k <= MAXC; k++) begin
        for (int i = 0; i < N; i++) dv[k][i] = ($urandom_range(0, 9) == 0);
        sv[k] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      end
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MAXC)) : 0;
      st_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MAXC)) : 0;
      do_run($sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
